// File: rtl/dataflow_merge.sv
// dataflow_merge: two-input valid/ready stream merge with round-robin
// arbitration and a single full-throughput output register stage. Each
// output word carries the index of the channel it came from in o_select.
module dataflow_merge #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [1:0]                i_valid,
  output logic [1:0]                i_ready,
  input  logic [2*DATA_WIDTH-1:0]   i_data,
  output logic                      o_valid,
  input  logic                      o_ready,
  output logic [DATA_WIDTH-1:0]     o_data,
  output logic                      o_select
);

  logic                  valid_reg;
  logic [DATA_WIDTH-1:0] data_reg;
  logic                  select_reg;
  // Channel served most recently; the other channel wins the next tie.
  logic                  last_grant_reg;

  logic                  load_en;
  logic                  any_valid;
  logic                  grant;
  logic [DATA_WIDTH-1:0] words [2];

  // Split the packed input bus into per-channel words and form the
  // per-channel ready. Ready is held low while reset is asserted so nothing
  // upstream believes a word was taken during reset.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
      assign words[gi]   = i_data[gi*DATA_WIDTH +: DATA_WIDTH];
      assign i_ready[gi] = reset_n && load_en && i_valid[gi] && (grant == 1'(gi));
    end
  endgenerate

  // Round-robin grant: on a tie serve the channel not served last time,
  // otherwise serve whichever channel is valid.
  always_comb begin
    load_en   = !valid_reg || o_ready;
    any_valid = |i_valid;
    grant     = (i_valid == 2'b11) ? ~last_grant_reg : i_valid[1];
  end

  // Output register stage: load the granted word whenever the register is
  // empty or being consumed this cycle, otherwise hold under backpressure.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_reg      <= 1'b0;
      data_reg       <= '0;
      select_reg     <= 1'b0;
      last_grant_reg <= 1'b1;
    end else if (load_en) begin
      if (any_valid) begin
        valid_reg      <= 1'b1;
        data_reg       <= words[grant];
        select_reg     <= grant;
        last_grant_reg <= grant;
      end else begin
        valid_reg      <= 1'b0;
      end
    end
  end

  assign o_valid  = valid_reg;
  assign o_data   = data_reg;
  assign o_select = select_reg;

endmodule

// File: tb/tb_dataflow_merge.sv
// tb_dataflow_merge: directed scenarios plus a randomized run checked against
// a behavioural model of the merge and an in-order scoreboard.
module tb_dataflow_merge;

  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [1:0]      i_valid;
  logic [1:0]      i_ready;
  logic [2*DW-1:0] i_data;
  logic            o_valid;
  logic            o_ready;
  logic [DW-1:0]   o_data;
  logic            o_select;

  int errors = 0;
  int checks = 0;

  // Behavioural model: what the output register should show and which
  // channel was served last.
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_sel;
  logic          m_last;

  dataflow_merge #(.DATA_WIDTH(DW)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_valid  (i_valid),
    .i_ready  (i_ready),
    .i_data   (i_data),
    .o_valid  (o_valid),
    .o_ready  (o_ready),
    .o_data   (o_data),
    .o_select (o_select)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] word_of(input logic k);
    return i_data[k*DW +: DW];
  endfunction

  // Which channel the arbiter should serve given current valids.
  function automatic logic pick();
    if (i_valid == 2'b11) return !m_last;
    return i_valid[1];
  endfunction

  // Ready the merge should present this cycle.
  function automatic logic [1:0] exp_ready();
    if (!reset_n) return 2'b00;
    if (m_valid && !o_ready) return 2'b00;
    if (i_valid == 2'b00) return 2'b00;
    return pick() ? 2'b10 : 2'b01;
  endfunction

  // Advance the model by one clock edge using the current inputs.
  function automatic void model_edge();
    logic p;
    if (!reset_n) begin
      m_valid = 1'b0; m_data = '0; m_sel = 1'b0; m_last = 1'b1;
    end else if (!m_valid || o_ready) begin
      if (i_valid != 2'b00) begin
        p = pick();
        m_valid = 1'b1; m_data = word_of(p); m_sel = p; m_last = p;
      end else begin
        m_valid = 1'b0;
      end
    end
  endfunction

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; o_ready = 1'b1; i_valid = 2'b11; i_data = {16'h2222, 16'h1111};
    for (int i = 0; i < 3; i++) tick();
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_o_valid got=%b exp=0", o_valid); end
    checks++; if (o_data !== 16'h0000) begin errors++; $display("FAIL reset_o_data got=%h exp=0000", o_data); end
    checks++; if (o_select !== 1'b0) begin errors++; $display("FAIL reset_o_select got=%b exp=0", o_select); end
    checks++; if (i_ready !== 2'b00) begin errors++; $display("FAIL reset_i_ready got=%b exp=00", i_ready); end
    $display("reset: held 3 cycles o_valid=%b i_ready=%b", o_valid, i_ready);
    reset_n = 1'b1;
    #1;
    checks++; if (i_ready !== 2'b01) begin errors++; $display("FAIL reset_first_ready got=%b exp=01", i_ready); end
    tick();
    checks++; if (o_valid !== 1'b1 || o_select !== 1'b0 || o_data !== 16'h1111) begin
      errors++; $display("FAIL reset_first_grant got=%b/%b/%h exp=1/0/1111", o_valid, o_select, o_data);
    end
    $display("reset: first output sel=%0d data=%h", o_select, o_data);
  endtask

  task automatic test_single();
    logic [DW-1:0] vals [2];
    vals[0] = 16'h1234; vals[1] = 16'h5678;
    o_ready = 1'b1; i_valid = 2'b10;
    for (int i = 0; i < 2; i++) begin
      i_data = {vals[i], 16'hDEAD};
      #1;
      checks++; if (i_ready !== 2'b10) begin errors++; $display("FAIL single_ready[%0d] got=%b exp=10", i, i_ready); end
      tick();
      checks++; if (o_valid !== 1'b1 || o_data !== vals[i] || o_select !== 1'b1) begin
        errors++; $display("FAIL single_out[%0d] got=%b/%h/%b exp=1/%h/1", i, o_valid, o_data, o_select, vals[i]);
      end
      $display("single: beat %0d data=%h sel=%0d", i, o_data, o_select);
    end
    i_valid = 2'b00;
    tick();
  endtask

  task automatic test_round_robin();
    logic [DW-1:0] c0, c1, exp_d;
    logic [1:0] r;
    c0 = 16'h0000; c1 = 16'h8000;
    o_ready = 1'b1; i_valid = 2'b11;
    for (int k = 0; k < 8; k++) begin
      i_data = {c1, c0};
      #1;
      r = exp_ready();
      checks++; if (i_ready !== r) begin errors++; $display("FAIL rr_ready[%0d] got=%b exp=%b", k, i_ready, r); end
      tick();
      exp_d = (k % 2 == 0) ? 16'(k / 2) : 16'(16'h8000 + k / 2);
      checks++; if (o_valid !== 1'b1 || o_select !== 1'(k % 2) || o_data !== exp_d) begin
        errors++; $display("FAIL rr_out[%0d] got=%b/%b/%h exp=1/%0d/%h", k, o_valid, o_select, o_data, k % 2, exp_d);
      end
      $display("rr: beat %0d sel=%0d data=%h", k, o_select, o_data);
      if (r[0]) c0++;
      if (r[1]) c1++;
    end
    i_valid = 2'b00;
    tick();
  endtask

  task automatic test_backpressure();
    o_ready = 1'b1; i_valid = 2'b01; i_data = {16'h0000, 16'h00AA};
    tick();
    o_ready = 1'b0; i_valid = 2'b10; i_data = {16'h00BB, 16'h0000};
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (i_ready !== 2'b00) begin errors++; $display("FAIL bp_ready[%0d] got=%b exp=00", i, i_ready); end
      tick();
      checks++; if (o_valid !== 1'b1 || o_data !== 16'h00AA || o_select !== 1'b0) begin
        errors++; $display("FAIL bp_hold[%0d] got=%b/%h/%b exp=1/00aa/0", i, o_valid, o_data, o_select);
      end
      $display("bp: stall %0d data=%h", i, o_data);
    end
    o_ready = 1'b1;
    #1;
    checks++; if (i_ready !== 2'b10) begin errors++; $display("FAIL bp_release_ready got=%b exp=10", i_ready); end
    tick();
    checks++; if (o_valid !== 1'b1 || o_data !== 16'h00BB || o_select !== 1'b1) begin
      errors++; $display("FAIL bp_next got=%b/%h/%b exp=1/00bb/1", o_valid, o_data, o_select);
    end
    $display("bp: released data=%h sel=%0d", o_data, o_select);
    i_valid = 2'b00;
    tick();
  endtask

  task automatic test_idle_drain();
    o_ready = 1'b1; i_valid = 2'b01; i_data = {16'h0000, 16'h0042};
    tick();
    checks++; if (o_valid !== 1'b1 || o_data !== 16'h0042) begin
      errors++; $display("FAIL drain_word got=%b/%h exp=1/0042", o_valid, o_data);
    end
    i_valid = 2'b00;
    tick();
    checks++; if (o_valid !== 1'b0 || o_data !== 16'h0042) begin
      errors++; $display("FAIL drain_idle got=%b/%h exp=0/0042", o_valid, o_data);
    end
    $display("drain: o_valid=%b data=%h", o_valid, o_data);
  endtask

  task automatic test_mid_reset();
    o_ready = 1'b0; i_valid = 2'b01; i_data = {16'h0000, 16'h0077};
    tick();
    checks++; if (o_valid !== 1'b1 || o_data !== 16'h0077) begin
      errors++; $display("FAIL midrst_load got=%b/%h exp=1/0077", o_valid, o_data);
    end
    reset_n = 1'b0; i_valid = 2'b00;
    tick();
    reset_n = 1'b1;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got=%b exp=0", o_valid); end
    o_ready = 1'b1;
    tick();
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL midrst_no_deliver got=%b exp=0", o_valid); end
    i_valid = 2'b11; i_data = {16'h0B0B, 16'h0A0A};
    #1;
    checks++; if (i_ready !== 2'b01) begin errors++; $display("FAIL midrst_ready got=%b exp=01", i_ready); end
    tick();
    checks++; if (o_select !== 1'b0 || o_data !== 16'h0A0A) begin
      errors++; $display("FAIL midrst_grant got=%b/%h exp=0/0a0a", o_select, o_data);
    end
    $display("midrst: after reset sel=%0d data=%h", o_select, o_data);
    i_valid = 2'b00;
    tick();
  endtask

  task automatic test_random();
    logic [16:0] sb_q[$];
    logic [16:0] exp_item;
    logic [1:0]  r;
    logic [1:0]  acc;
    int          n_out;
    acc = 2'b00; n_out = 0;
    sb_q.delete();
    if (m_valid) sb_q.push_back({m_sel, m_data});
    for (int cyc = 0; cyc < 400; cyc++) begin
      // Upstream keeps a pending word stable until it is taken.
      for (int k = 0; k < 2; k++) begin
        if (!(i_valid[k] && !acc[k])) begin
          i_valid[k] = 1'($urandom_range(0, 1));
          i_data[k*DW +: DW] = 16'($urandom);
        end
      end
      o_ready = ($urandom_range(0, 3) != 0);
      #1;
      r = exp_ready();
      checks++; if (i_ready !== r) begin errors++; $display("FAIL rnd_ready[%0d] got=%b exp=%b", cyc, i_ready, r); end
      if (o_valid && o_ready) begin
        exp_item = (sb_q.size() > 0) ? sb_q.pop_front() : 17'h1FFFF;
        checks++; if ({o_select, o_data} !== exp_item) begin
          errors++; $display("FAIL rnd_order[%0d] got=%b/%h exp=%b/%h", cyc, o_select, o_data, exp_item[16], exp_item[15:0]);
        end
        n_out++;
      end
      if (r[0]) sb_q.push_back({1'b0, word_of(1'b0)});
      if (r[1]) sb_q.push_back({1'b1, word_of(1'b1)});
      acc = r;
      tick();
      checks++; if (o_valid !== m_valid || o_data !== m_data || o_select !== m_sel) begin
        errors++; $display("FAIL rnd_out[%0d] got=%b/%h/%b exp=%b/%h/%b", cyc, o_valid, o_data, o_select, m_valid, m_data, m_sel);
      end
    end
    $display("random: 400 cycles, %0d words delivered", n_out);
    i_valid = 2'b00; o_ready = 1'b1;
    tick();
  endtask

  initial begin
    reset_n = 1'b0; i_valid = 2'b00; i_data = '0; o_ready = 1'b0;
    m_valid = 1'b0; m_data = '0; m_sel = 1'b0; m_last = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_idle_drain();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
